ifetch_unit: RTL and testbench

//  Instruction-fetch stage immediately downstream of the PC register. Drives imem from the current PC.

---
 rtl/ifetch_unit_if.sv | 52 +++++
 rtl/ifetch_unit.sv | 130 +++++++++++++
 tb/tb_ifetch_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Signal bundle between the fetch stage and its neighbours: PC register, imem and decode.
// The master view is the fetch unit itself; the slave view is everything around it.
interface ifetch_unit_if;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        pc_ena;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_err;

    modport master (
        input  pc_in,
        output pc_next,
        output pc_ena,
        input  redirect_valid,
        input  redirect_target,
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output inst_err
    );

    modport slave (
        output pc_in,
        input  pc_next,
        input  pc_ena,
        output redirect_valid,
        output redirect_target,
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  inst_err
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: drives imem from the current PC, buffers one instruction for
// decode, and feeds the next PC (sequential or redirect) back to the PC register.
module ifetch_unit #(
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] INST_NOP = 32'h0,
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0]        ERR_OK       = 2'b00;
    localparam logic [1:0]        ERR_MISALIGN = 2'b01;
    localparam logic [1:0]        ERR_TIMEOUT  = 2'b10;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT   = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE     = WAIT_W'(1);

    state_t            state_q, state_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       inst_pc_q, inst_pc_d;
    logic [1:0]        inst_err_q, inst_err_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic aligned;
    logic in_fetch;
    logic fetch_go;

    assign aligned  = (bus.pc_in[1:0] == 2'b00);
    assign in_fetch = (state_q == FETCH);
    // A fetch is only issued from an aligned PC; misaligned PCs become error entries.
    assign fetch_go = in_fetch && aligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            inst_q     <= INST_NOP;
            inst_pc_q  <= '0;
            inst_err_q <= ERR_OK;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            inst_err_q <= inst_err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;
        wait_cnt_d = wait_cnt_q;
        if (bus.redirect_valid) begin
            // Redirect wins over everything: any buffered entry or same-cycle ack is dropped.
            state_d    = FETCH;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (!aligned) begin
                        state_d    = FULL;
                        inst_d     = INST_NOP;
                        inst_pc_d  = bus.pc_in;
                        inst_err_d = ERR_MISALIGN;
                        wait_cnt_d = '0;
                    end else if (bus.imem_ack) begin
                        state_d    = FULL;
                        inst_d     = bus.imem_rdata;
                        inst_pc_d  = bus.pc_in;
                        inst_err_d = ERR_OK;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        state_d    = FULL;
                        inst_d     = INST_NOP;
                        inst_pc_d  = bus.pc_in;
                        inst_err_d = ERR_TIMEOUT;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end
                end
                FULL: begin
                    if (bus.inst_ready) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.pc_ena   = 1'b0;
        bus.pc_next  = bus.pc_in;
        // Gating with rst keeps the PC register untouched while reset is held.
        if (rst) begin
            bus.imem_req = fetch_go;
            if (bus.redirect_valid) begin
                bus.pc_ena  = 1'b1;
                bus.pc_next = bus.redirect_target;
            end else if (fetch_go && bus.imem_ack) begin
                bus.pc_ena  = 1'b1;
                bus.pc_next = bus.pc_in + PC_STEP;
            end
        end
    end

    assign bus.imem_addr  = bus.pc_in;
    assign bus.inst_valid = (state_q == FULL);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_err   = inst_err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios followed by randomized traffic, all checked
// against a queue-based reference model that also plays the role of the PC register.
module tb_ifetch_unit;

    localparam int unsigned MAX_WAIT = 15;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic [1:0]  err;
    } entry_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ifetch_unit_if bus();

    ifetch_unit #(
        .PC_STEP  (32'd4),
        .INST_NOP (32'h0),
        .WAIT_W   (4),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    entry_t      q[$];
    bit          started;
    int          waited;
    logic [31:0] pc_reg;
    int          n_checks = 0;
    int          n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Asserts reset with hostile inputs, checks outputs immediately, then releases it.
    task automatic do_reset(input int hold, input logic [31:0] pc);
        rst                 = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h1234_5670;
        bus.imem_ack        = 1'b1;
        bus.imem_rdata      = 32'hFFFF_FFFF;
        bus.inst_ready      = 1'b1;
        bus.pc_in           = pc;
        #1;
        chk("rst_imem_req",   32'(bus.imem_req),   32'd0);
        chk("rst_pc_ena",     32'(bus.pc_ena),     32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst",       bus.inst,            32'h0);
        chk("rst_inst_pc",    bus.inst_pc,         32'h0);
        chk("rst_inst_err",   32'(bus.inst_err),   32'd0);
        repeat (hold) @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_hold_req",   32'(bus.imem_req),   32'd0);
        q.delete();
        started = 1'b0;
        waited  = 0;
        pc_reg  = pc;
        bus.redirect_valid = 1'b0;
        bus.imem_ack       = 1'b0;
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic step(input bit rd, input logic [31:0] tgt, input bit ack,
                        input logic [31:0] rdata, input bit rdy);
        bit          fetching;
        bit          e_req;
        bit          e_ena;
        logic [31:0] e_next;
        bus.pc_in           = pc_reg;
        bus.redirect_valid  = rd;
        bus.redirect_target = tgt;
        bus.imem_ack        = ack;
        bus.imem_rdata      = rdata;
        bus.inst_ready      = rdy;
        #1;
        fetching = started && (q.size() == 0);
        e_req    = fetching && (pc_reg[1:0] == 2'b00);
        e_ena    = rd || (e_req && ack);
        e_next   = rd ? tgt : ((e_req && ack) ? pc_reg + 32'd4 : pc_reg);
        chk("imem_req",   32'(bus.imem_req),   32'(e_req));
        if (e_req) chk("imem_addr", bus.imem_addr, pc_reg);
        chk("pc_ena",     32'(bus.pc_ena),     32'(e_ena));
        chk("pc_next",    bus.pc_next,         e_next);
        chk("inst_valid", 32'(bus.inst_valid), 32'(q.size() == 1));
        if (q.size() == 1) begin
            chk("inst",     bus.inst,          q[0].word);
            chk("inst_pc",  bus.inst_pc,       q[0].pc);
            chk("inst_err", 32'(bus.inst_err), 32'(q[0].err));
        end
        @(posedge clk);
        if (rd) begin
            q.delete();
            started = 1'b1;
            waited  = 0;
        end else if (!started) begin
            started = 1'b1;
        end else if (q.size() != 0) begin
            if (rdy) void'(q.pop_front());
        end else if (pc_reg[1:0] != 2'b00) begin
            q.push_back('{word: 32'h0, pc: pc_reg, err: 2'b01});
            waited = 0;
        end else if (ack) begin
            q.push_back('{word: rdata, pc: pc_reg, err: 2'b00});
            waited = 0;
        end else if (waited == int'(MAX_WAIT)) begin
            q.push_back('{word: 32'h0, pc: pc_reg, err: 2'b10});
            waited = 0;
        end else begin
            waited++;
        end
        if (e_ena) pc_reg = e_next;
        #1;
    endtask

    initial begin
        int unsigned ack_pct;
        int unsigned rd_pct;
        logic [31:0] tgt;
        rst                 = 1'b1;
        bus.pc_in           = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = '0;
        bus.inst_ready      = 1'b0;
        #2;

        // Reset release, immediate ack, immediate pop
        do_reset(2, 32'h0040_0000);
        step(0, 32'h0, 0, 32'h0, 1);
        step(0, 32'h0, 1, 32'h2008_0005, 1);
        step(0, 32'h0, 0, 32'h0, 1);

        // Ack after three wait cycles, then decode stalls four cycles
        repeat (3) step(0, 32'h0, 0, 32'hBAD0_BAD0, 0);
        step(0, 32'h0, 1, 32'h1234_ABCD, 0);
        repeat (4) step(0, 32'h0, 0, 32'h0, 0);
        step(0, 32'h0, 0, 32'h0, 1);

        // Timeout after MAX_WAIT+1 silent cycles, then pop the error entry
        repeat (MAX_WAIT + 1) step(0, 32'h0, 0, 32'h0, 0);
        step(0, 32'h0, 0, 32'h0, 0);
        step(0, 32'h0, 0, 32'h0, 1);

        // Redirect colliding with an ack, then redirect colliding with a pop
        step(1, 32'h0040_0100, 1, 32'hDEAD_BEEF, 1);
        step(0, 32'h0, 1, 32'h0000_1111, 0);
        step(1, 32'h0040_0100, 0, 32'h0, 1);
        step(0, 32'h0, 1, 32'h0000_2222, 1);
        step(0, 32'h0, 0, 32'h0, 1);

        // Misaligned target, then wrap-around at the top of the address space
        step(1, 32'h0040_0002, 0, 32'h0, 0);
        step(0, 32'h0, 1, 32'h5555_5555, 0);
        step(0, 32'h0, 0, 32'h0, 1);
        step(0, 32'h0, 1, 32'h6666_6666, 0);
        step(1, 32'hFFFF_FFFC, 0, 32'h0, 1);
        step(0, 32'h0, 1, 32'h7777_7777, 1);
        step(0, 32'h0, 0, 32'h0, 1);

        // Reset while waiting on an ack
        repeat (3) step(0, 32'h0, 0, 32'h0, 0);
        do_reset(2, 32'h0040_0000);
        step(0, 32'h0, 1, 32'h8888_8888, 1);
        step(0, 32'h0, 1, 32'h9999_9999, 1);
        step(0, 32'h0, 0, 32'h0, 1);

        // Randomized traffic in phases of differing ack and redirect density
        for (int i = 0; i < 3000; i++) begin
            case ((i / 250) % 4)
                0:       begin ack_pct = 70; rd_pct = 5; end
                1:       begin ack_pct = 20; rd_pct = 3; end
                2:       begin ack_pct = 0;  rd_pct = 0; end
                default: begin ack_pct = 40; rd_pct = 8; end
            endcase
            if ((i % 250) == 0 && ((i / 250) % 4) == 2) begin
                step(1, {$urandom_range(0, 32'h00FF_FFFF), 2'b00} , 0, 32'h0, 1);
            end else if ($urandom_range(0, 599) == 0) begin
                do_reset(1 + $urandom_range(0, 2), {$urandom(), 2'b00} >> 2 << 2);
            end else begin
                tgt = $urandom();
                if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
                if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFFC;
                step($urandom_range(0, 99) < rd_pct, tgt,
                     $urandom_range(0, 99) < ack_pct, $urandom(),
                     $urandom_range(0, 1) == 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
